regfile_multiport: RTL and testbench

//  Parametrised successor to the single-write/dual-read ARMv8 register file used by the monocycle datapath.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_clear_seq.sv | 63 ++++++
 rtl/regfile_multiport.sv | 102 ++++++++++
 tb/tb_regfile_multiport.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
// Holds the clear-FSM state type, the depth function and the zero-index rule.
package regfile_pkg;

  // One-bit encoding: IDLE=0, CLEAR=1.
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_MAX_RD = 4;

  function automatic int rf_depth(input int aw);
    return 1 << aw;
  endfunction

  // A ZERO_IDX outside 0..DEPTH-1 (normally DEPTH)
  // turns the hardwired zero register off.
  function automatic bit rf_zero_en(
    input int zidx,
    input int aw
  );
    return (zidx >= 0) && (zidx < rf_depth(aw));
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Self-timed clear sequencer: sweeps every address writing zero.
// Ports: clk, reset (async high), clr_start in; busy, clr_we, clr_addr out.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  rf_state_t         state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (1'b1)
      (state == RF_IDLE): begin
        if (clr_start) begin
          state_nxt = RF_CLEAR;
        end
      end
      (state == RF_CLEAR): begin
        // cnt wraps to 0 at LAST: that wrap is the exit.
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_nxt = RF_IDLE;
        end
      end
      default: begin
        state_nxt = RF_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset lands in CLEAR so the array is zeroed by the sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RF_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy     = (state == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read register file with hardwired zero and clear sweep.
// Ports: clk, reset, clr_start, busy, rd_addr/rd_data (packed), wr, wr_addr, wr_data.
// Build macro RF_BYPASS_EN: same-cycle write-to-read forwarding when defined.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_IDX = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_start,
  output logic                     busy,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);

  localparam int DEPTH   = rf_depth(ADDR_W);
  localparam bit ZERO_EN =
    rf_zero_en(ZERO_IDX, ADDR_W);
  localparam logic [ADDR_W-1:0] ZADDR =
    ZERO_EN ? ADDR_W'(ZERO_IDX) : '0;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return ZERO_EN && (a == ZADDR);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_start(clr_start),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign user_we = wr && !busy
                && !is_zero(wr_addr);

  // Sweep owns the port while busy;
  // user writes are dropped then.
  always_comb begin
    we = 1'b0;
    wa = wr_addr;
    wd = wr_data;
    if (clr_we) begin
      we = 1'b1;
      wa = clr_addr;
      wd = '0;
    end else if (user_we) begin
      we = 1'b1;
    end
  end

  // Storage is not reset: the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      d = mem[ra];
`ifdef RF_BYPASS_EN
      if (user_we && (ra == wr_addr)) begin
        d = wr_data;
      end
`endif
      // Zero register and busy win over bypass.
      if (busy || is_zero(ra)) begin
        d = '0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (DEPTH=32, two read ports).
// Stimulus queues expectations; a negedge monitor pops and compares them.
module tb_regfile_multiport;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk;
  logic            reset;
  logic            clr_start;
  logic            busy;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic            wr;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  regfile_multiport #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .ZERO_IDX(31)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clr_start(clr_start),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr       (wr),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_busy;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_pass;
  int   n_tot;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] got;
      e = q.pop_front();
      if (e.is_busy) got = {63'd0, busy};
      else got = rd_data[e.port*DW +: DW];
      n_tot++;
      if (got === e.exp) n_pass++;
      else $display("FAIL %s: got %h want %h",
                    e.name, got, e.exp);
    end
  end

  task automatic chk(input string n,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  n, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_busy(input string n,
                          input logic b);
    exp_t e;
    e.name = n; e.is_busy = 1'b1;
    e.port = 0; e.exp = {63'd0, b};
    q.push_back(e);
  endtask

  task automatic exp_rd(input string n,
                        input int p,
                        input logic [63:0] v);
    exp_t e;
    e.name = n; e.is_busy = 1'b0;
    e.port = p; e.exp = v;
    q.push_back(e);
  endtask

  task automatic set_rd(input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic check_all_zero(input string n);
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(31 - a));
      exp_rd(n, 0, 64'd0);
      exp_rd(n, 1, 64'd0);
      tick();
    end
  endtask

  task automatic sweep_timing(input string n);
    for (int c = 1; c <= 31; c++) tick();
    exp_busy({n, "_still_busy"}, 1'b1);
    tick();
    chk({n, "_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    n_pass = 0;
    n_tot = 0;
    reset = 1'b1;
    clr_start = 1'b0;
    wr = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    #1;
    exp_busy("reset_busy", 1'b1);
    set_rd(5'd5, 5'd0);
    exp_rd("reset_rd0", 0, 64'd0);
    #0;
    chk("reset_busy_now", {63'd0, busy}, 64'd1);
    chk("reset_rd0_now", rd_data[0 +: DW], 64'd0);
    tick();
    tick();
    reset = 1'b0;
    exp_rd("sweep_rd_busy", 0, 64'd0);
    sweep_timing("reset_sweep");
    tick();
    check_all_zero("after_reset_zero");

    wr = 1'b1; wr_addr = 5'd5;
    wr_data = 64'hDEAD_BEEF_0123_4567;
    set_rd(5'd5, 5'd6);
    exp_rd("wr5_same_cycle", 0,
           BYP ? 64'hDEAD_BEEF_0123_4567 : 64'd0);
    exp_rd("rd6_untouched", 1, 64'd0);
    tick();
    wr = 1'b0;
    set_rd(5'd5, 5'd5);
    exp_rd("rd5_port0", 0, 64'hDEAD_BEEF_0123_4567);
    exp_rd("rd5_port1", 1, 64'hDEAD_BEEF_0123_4567);
    tick();

    wr = 1'b1; wr_addr = 5'd31;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    set_rd(5'd31, 5'd31);
    exp_rd("zero_byp_p0", 0, 64'd0);
    exp_rd("zero_byp_p1", 1, 64'd0);
    tick();
    wr = 1'b0;
    exp_rd("zero_after_p0", 0, 64'd0);
    exp_rd("zero_after_p1", 1, 64'd0);
    tick();

    wr = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234;
    set_rd(5'd5, 5'd7);
    exp_rd("byp_p1", 1, BYP ? 64'h1234 : 64'd0);
    exp_rd("byp_p0_other", 0,
           64'hDEAD_BEEF_0123_4567);
    tick();
    wr = 1'b0;
    exp_rd("rd7_after", 1, 64'h1234);
    tick();

    for (int a = 0; a <= 30; a++) begin
      wr = 1'b1; wr_addr = AW'(a); wr_data = 64'(a);
      tick();
    end
    wr = 1'b0;
    set_rd(5'd1, 5'd30);
    exp_rd("fill_r1", 0, 64'd1);
    exp_rd("fill_r30", 1, 64'd30);
    tick();
    set_rd(5'd5, 5'd9);
    exp_rd("fill_r5", 0, 64'd5);
    exp_rd("fill_r9", 1, 64'd9);
    tick();

    clr_start = 1'b1;
    wr = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
    exp_busy("clr_idle_busy", 1'b0);
    tick();
    clr_start = 1'b0;
    exp_busy("clr_busy_rise", 1'b1);
    set_rd(5'd3, 5'd30);
    exp_rd("clr_rd_busy", 1, 64'd0);
    wr = 1'b1; wr_addr = 5'd3; wr_data = 64'hABC;
    tick();
    wr = 1'b0;
    clr_start = 1'b1;
    for (int c = 2; c <= 31; c++) begin
      if (c == 6) clr_start = 1'b0;
      tick();
    end
    exp_busy("clr_still_busy", 1'b1);
    tick();
    exp_busy("clr_done", 1'b0);
    set_rd(5'd3, 5'd9);
    exp_rd("clr_wr3_dropped", 0, 64'd0);
    exp_rd("clr_wr9_erased", 1, 64'd0);
    tick();
    check_all_zero("after_clr_zero");

    wr = 1'b1; wr_addr = 5'd20; wr_data = 64'h20;
    tick();
    wr = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    exp_busy("mid_pre_reset", 1'b1);
    reset = 1'b1;
    #1;
    exp_busy("mid_reset_busy", 1'b1);
    tick();
    tick();
    reset = 1'b0;
    sweep_timing("mid_sweep");
    set_rd(5'd20, 5'd0);
    exp_rd("mid_r20_zero", 0, 64'd0);
    tick();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
